gf2_linear_xform32: RTL and testbench



---
 rtl/nlu_pkg.sv | 28 ++
 rtl/gf2_linear_xform32_if.sv | 32 +++
 rtl/gf2_linear_xform32_row_dot.sv | 19 +
 rtl/gf2_linear_xform32.sv | 76 +++++++
 tb/tb_gf2_linear_xform32.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/nlu_pkg.sv
// -----------------------------------------------------------------------------
// nlu_pkg
// Shared definitions for the nonlinear/linear compute unit.
//   N       : operand vector width (the mask matrix is N x N)
//   CHUNK   : maximum number of mask bits accepted per push
//   MASK_W  : total number of mask bits (N*N)
//   sel_t   : 4-bit push-width encoding (0 = full CHUNK, 1..15 = that many bits)
//   parity32   : XOR-reduction of a 32-bit word
//   sel_width  : decodes sel_t into an actual bit count (1..16)
// -----------------------------------------------------------------------------
package nlu_pkg;

   localparam int N      = 32;
   localparam int CHUNK  = 16;
   localparam int MASK_W = N * N;

   typedef logic [3:0] sel_t;

   function automatic logic parity32(input logic [31:0] v);
      return ^v;
   endfunction

   // 0 encodes a full chunk so that the 4-bit field covers 1..16 bits.
   function automatic logic [4:0] sel_width(input sel_t s);
      return (s == 4'd0) ? 5'd16 : {1'b0, s};
   endfunction

endpackage

// File: rtl/gf2_linear_xform32_if.sv
// -----------------------------------------------------------------------------
// gf2_linear_xform32_if
// Bus bundle for the GF(2) linear transform.
//   push, sel, cfg_din : serial mask load port (cfg_din consumed MSB-first)
//   a, a_vld           : operand vector and its valid strobe
//   acc                : accumulate select (only when LINXF_ACC_EN is defined)
//   y, y_vld           : registered result and its valid flag
// Modports: master drives operands/config, slave is the transform block.
// -----------------------------------------------------------------------------
interface gf2_linear_xform32_if;
   import nlu_pkg::*;

   logic             push;
   sel_t             sel;
   logic [CHUNK-1:0] cfg_din;
   logic [N-1:0]     a;
   logic             a_vld;
`ifdef LINXF_ACC_EN
   logic             acc;
`endif
   logic [N-1:0]     y;
   logic             y_vld;

`ifdef LINXF_ACC_EN
   modport master (output push, sel, cfg_din, a, a_vld, acc, input y, y_vld);
   modport slave  (input push, sel, cfg_din, a, a_vld, acc, output y, y_vld);
`else
   modport master (output push, sel, cfg_din, a, a_vld, input y, y_vld);
   modport slave  (input push, sel, cfg_din, a, a_vld, output y, y_vld);
`endif

endinterface

// File: rtl/gf2_linear_xform32_row_dot.sv
// -----------------------------------------------------------------------------
// gf2_row_dot32
// One row of the GF(2) matrix-vector product: dot = XOR_j (row[j] & a[j]).
//   row : 32-bit matrix row
//   a   : 32-bit operand
//   dot : parity of the bitwise AND
// Purely combinational; the top module registers the result.
// -----------------------------------------------------------------------------
module gf2_row_dot32
   import nlu_pkg::*;
(
   input  logic [31:0] row,
   input  logic [31:0] a,
   output logic        dot
);

   assign dot = parity32(row & a);

endmodule

// File: rtl/gf2_linear_xform32.sv
// -----------------------------------------------------------------------------
// gf2_linear_xform32
// Configurable 32x32 linear transform over GF(2): y = M * a.
// The 1024-bit mask M is a left shift register loaded 1..16 bits per push,
// new bits entering at the LSB. Row i of M is mask[32i+31:32i].
//   ck  : clock, all state changes on the rising edge
//   rst : synchronous active-high reset (clears mask, y, y_vld)
//   bus : gf2_linear_xform32_if.slave (push/sel/cfg_din, a/a_vld, y/y_vld)
// Result latency is one cycle; y holds its value when a_vld is low.
// Optional macro LINXF_ACC_EN adds bus.acc: when set with a_vld, the new
// product is XORed into the previous y instead of replacing it.
// -----------------------------------------------------------------------------
module gf2_linear_xform32
   import nlu_pkg::*;
(
   input  logic                  ck,
   input  logic                  rst,
   gf2_linear_xform32_if.slave   bus
);

   logic [MASK_W-1:0] mask_reg;
   logic [MASK_W-1:0] mask_next;
   logic [N-1:0]      prod;
   logic [N-1:0]      y_reg;
   logic [N-1:0]      y_next;
   logic              y_vld_reg;
   logic [4:0]        width;
   logic [4:0]        shamt;

   // Variable-width shift: the top `width` bits of cfg_din are right-aligned
   // and OR-ed into the vacated LSBs; bits leaving mask[1023] are dropped.
   always_comb begin
      width     = sel_width(bus.sel);
      shamt     = 5'(CHUNK) - width;
      mask_next = (mask_reg << width) | MASK_W'(bus.cfg_din >> shamt);
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         gf2_row_dot32 u_row (
            .row (mask_reg[gi*N +: N]),
            .a   (bus.a),
            .dot (prod[gi])
         );
      end
   endgenerate

`ifdef LINXF_ACC_EN
   assign y_next = bus.acc ? (y_reg ^ prod) : prod;
`else
   assign y_next = prod;
`endif

   // The product is taken from mask_reg before this edge's push lands, so a
   // push and an operand in the same cycle see the old matrix.
   always_ff @(posedge ck) begin
      if (rst) begin
         mask_reg  <= '0;
         y_reg     <= '0;
         y_vld_reg <= 1'b0;
      end else begin
         if (bus.push) begin
            mask_reg <= mask_next;
         end
         if (bus.a_vld) begin
            y_reg <= y_next;
         end
         y_vld_reg <= bus.a_vld;
      end
   end

   assign bus.y     = y_reg;
   assign bus.y_vld = y_vld_reg;

endmodule

// File: tb/tb_gf2_linear_xform32.sv
// -----------------------------------------------------------------------------
// tb_gf2_linear_xform32
// Directed testbench for gf2_linear_xform32. A bit-level reference model of
// the mask (array of single bits, shifted one bit at a time) and of the
// matrix-vector product is checked against the DUT every cycle, and literal
// expected values pin the model at the key points.
// Accumulate tests are included when LINXF_ACC_EN is defined.
// -----------------------------------------------------------------------------
module tb_gf2_linear_xform32;
   import nlu_pkg::*;

   logic ck = 1'b0;
   logic rst;
   always #5 ck = ~ck;

   gf2_linear_xform32_if bus ();

   gf2_linear_xform32 dut (
      .ck  (ck),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   bit          mdl [MASK_W];
   logic [31:0] exp_y;
   logic        exp_vld;
   bit          cmp_en = 1'b0;
   logic [MASK_W-1:0] id_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, req);
      end
   endtask

   // y[i] = XOR over j of (M[i][j] & v[j]), evaluated bit by bit.
   function automatic logic [31:0] mdl_mul(input logic [31:0] v);
      logic [31:0] r = '0;
      for (int i = 0; i < 32; i++)
         for (int j = 0; j < 32; j++)
            if (mdl[32*i+j] && v[j]) r[i] = ~r[i];
      return r;
   endfunction

   // One clock of stimulus; the model is advanced right after the edge.
   task automatic step(input logic r, input logic p, input logic [3:0] s,
                       input logic [15:0] d, input logic v, input logic [31:0] av,
                       input logic ac);
      int n;
      rst         = r;
      bus.push    = p;
      bus.sel     = s;
      bus.cfg_din = d;
      bus.a_vld   = v;
      bus.a       = av;
`ifdef LINXF_ACC_EN
      bus.acc     = ac;
`endif
      @(posedge ck);
      if (r) begin
         for (int k = 0; k < MASK_W; k++) mdl[k] = 1'b0;
         exp_y   = '0;
         exp_vld = 1'b0;
      end else begin
         if (v) exp_y = ac ? (exp_y ^ mdl_mul(av)) : mdl_mul(av);
         exp_vld = v;
         if (p) begin
            n = (s == 4'd0) ? 16 : int'(s);
            for (int b = 0; b < n; b++) begin
               for (int k = MASK_W - 1; k > 0; k--) mdl[k] = mdl[k-1];
               mdl[0] = d[15-b];
            end
         end
      end
      txn++;
      $display("txn %0d rst=%0b push=%0b sel=%0d din=%04h a_vld=%0b a=%08h acc=%0b -> y=%08h vld=%0b",
               txn, r, p, s, d, v, av, ac, exp_y, exp_vld);
      @(negedge ck);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic load_identity();
      for (int c = MASK_W/16 - 1; c >= 0; c--)
         step(1'b0, 1'b1, 4'd0, id_v[16*c +: 16], 1'b0, 32'h0, 1'b0);
   endtask

   task automatic apply(input logic [31:0] av, input logic ac);
      step(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, av, ac);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge ck) begin
      if (cmp_en) begin
         chk("y_vld", {31'b0, bus.y_vld}, {31'b0, exp_vld});
         chk("y", bus.y, exp_y);
      end
   end

   initial begin
      logic [3:0]  mix_sel [6] = '{4'd15, 4'd3, 4'd0, 4'd7, 4'd1, 4'd9};
      logic [15:0] mix_din [6] = '{16'h1234, 16'hE000, 16'hBEEF, 16'h5A00, 16'h8000, 16'hC3C3};
      logic [31:0] mix_a   [5] = '{32'h00000001, 32'hFFFFFFFF, 32'h0000FFFF, 32'hA5A5A5A5, 32'h80000001};

      id_v = '0;
      for (int i = 0; i < 32; i++) id_v[33*i] = 1'b1;
      exp_y   = '0;
      exp_vld = 1'b0;
      rst = 1'b1;
      bus.push = 1'b0; bus.sel = '0; bus.cfg_din = '0; bus.a = '0; bus.a_vld = 1'b0;
`ifdef LINXF_ACC_EN
      bus.acc = 1'b0;
`endif
      @(negedge ck);
      do_reset();
      do_reset();
      cmp_en = 1'b1;
      chk("reset_y", bus.y, 32'h0);
      chk("reset_vld", {31'b0, bus.y_vld}, 32'h0);

      // Empty mask: any operand gives zero.
      apply(32'hFFFFFFFF, 1'b0);
      chk("zero_mask_y", bus.y, 32'h00000000);
      chk("zero_mask_vld", {31'b0, bus.y_vld}, 32'h1);

      // All-ones mask.
      for (int c = 0; c < 64; c++) step(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 32'h0, 1'b0);
      apply(32'h00000001, 1'b0);
      chk("ones_a1", bus.y, 32'hFFFFFFFF);
      chk("model_ones_a1", exp_y, 32'hFFFFFFFF);
      apply(32'h00000003, 1'b0);
      chk("ones_a3", bus.y, 32'h00000000);
      idle();
      chk("hold_y", bus.y, 32'h00000000);
      chk("hold_vld", {31'b0, bus.y_vld}, 32'h0);

      // Identity mask.
      do_reset();
      load_identity();
      apply(32'hDEADBEEF, 1'b0);
      chk("ident_deadbeef", bus.y, 32'hDEADBEEF);
      chk("model_ident", exp_y, 32'hDEADBEEF);
      apply(32'h12345678, 1'b0);
      chk("ident_12345678", bus.y, 32'h12345678);

      // Partial widths; low cfg_din bits must be ignored.
      do_reset();
      step(1'b0, 1'b1, 4'd4, 16'hA05F, 1'b0, 32'h0, 1'b0);
      apply(32'h00000002, 1'b0);
      chk("sel4_a2", bus.y, 32'h00000001);
      apply(32'h0000000A, 1'b0);
      chk("sel4_aA", bus.y, 32'h00000000);
      step(1'b0, 1'b1, 4'd1, 16'hC123, 1'b0, 32'h0, 1'b0);
      apply(32'h00000001, 1'b0);
      chk("sel1_a1", bus.y, 32'h00000001);
      apply(32'h00000010, 1'b0);
      chk("sel1_a10", bus.y, 32'h00000001);

      // Push together with an operand: old mask m[4:0]=10101 applies.
      step(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 32'h00000002, 1'b0);
      chk("push_same_cycle_old", bus.y, 32'h00000000);
      apply(32'h00010001, 1'b0);
      chk("push_new_mask", bus.y, 32'h00000000);
      apply(32'h00000002, 1'b0);
      chk("push_new_mask_a2", bus.y, 32'h00000001);

      // Reset mid-stream beats push and a_vld.
      step(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1, 32'hFFFFFFFF, 1'b0);
      chk("mid_reset_y", bus.y, 32'h0);
      chk("mid_reset_vld", {31'b0, bus.y_vld}, 32'h0);
      apply(32'hFFFFFFFF, 1'b0);
      chk("mid_reset_mask_clear", bus.y, 32'h0);

      // Mixed widths, checked against the model only.
      for (int r = 0; r < 12; r++) begin
         for (int k = 0; k < 6; k++)
            step(1'b0, 1'b1, mix_sel[k], mix_din[k] ^ 16'(r * 16'h1111), 1'b0, 32'h0, 1'b0);
      end
      for (int k = 0; k < 5; k++) apply(mix_a[k], 1'b0);

`ifdef LINXF_ACC_EN
      do_reset();
      load_identity();
      apply(32'h0000FFFF, 1'b0);
      chk("acc0", bus.y, 32'h0000FFFF);
      apply(32'h00FF00FF, 1'b1);
      chk("acc1", bus.y, 32'h00FFFF00);
      idle();
      apply(32'hF0000000, 1'b1);
      chk("acc_after_idle", bus.y, 32'hF0FFFF00);
`endif

      idle();
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
